// File: rtl/ysyx_23060077_ex_div_pkg.sv
// rtl/ysyx_23060077_ex_div_pkg.sv - shared widths, constants and helpers for the divider
// Purpose: operand width from the core define file, counter width and a
//          two's-complement magnitude helper used when preparing operands.
// Ports: none (package).
`include "ysyx_23060077_define.v"

package ysyx_23060077_ex_div_pkg;

    localparam int DW = `YSYX_23060077_DATA_WIDTH;
    localparam int CW = $clog2(DW);

    // Most negative signed value; also the signed-overflow quotient.
    localparam logic [DW-1:0] INT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Magnitude of v, treating it as signed only when is_signed is set.
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic is_signed);
        return (is_signed && v[DW-1]) ? ({DW{1'b0}} - v) : v;
    endfunction

endpackage

// File: rtl/ysyx_23060077_ex_div_if.sv
// rtl/ysyx_23060077_ex_div_if.sv - request/result bundle between the EX stage and the divider
// Purpose: groups the divider's request, flush and result signals.
// Signals: div_signed, dividend, divisor, flush, div_valid (requester -> divider)
//          div_ready, out_valid, quotient, remainder (divider -> requester)
// Modports: master = requester, slave = divider.
interface ysyx_23060077_ex_div_if;
    import ysyx_23060077_ex_div_pkg::*;

    logic          div_signed;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          flush;
    logic          div_valid;
    logic          div_ready;
    logic          out_valid;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;

    modport master (
        output div_signed, dividend, divisor, flush, div_valid,
        input  div_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  div_signed, dividend, divisor, flush, div_valid,
        output div_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/ysyx_23060077_define.v
// rtl/ysyx_23060077_define.v - shared width defines for the ysyx_23060077 core
// Optional feature macro: YSYX_23060077_DIV_FAST_SPECIAL_EN
//   When defined, the divider finishes divide-by-zero and signed overflow
//   in its PREP state (latency 1). Define it here or on the command line.
`ifndef YSYX_23060077_DEFINE_V
`define YSYX_23060077_DEFINE_V

`define YSYX_23060077_DATA_WIDTH 32

`endif

// File: rtl/ysyx_23060077_div_step.sv
// rtl/ysyx_23060077_div_step.sv - one radix-2 restoring division step (combinational)
// Purpose: shifts the 64-bit partial remainder left by one and trial-subtracts
//          the divisor magnitude from its upper half.
// Ports: rem_in  - partial remainder {upper remainder, dividend/quotient bits}
//        divisor - divisor magnitude
//        rem_out - next partial remainder, LSB left 0 for the quotient bit
//        q_bit   - quotient bit of this step
module ysyx_23060077_div_step
    import ysyx_23060077_ex_div_pkg::*;
(
    input  logic [2*DW-1:0] rem_in,
    input  logic [DW-1:0]   divisor,
    output logic [2*DW-1:0] rem_out,
    output logic            q_bit
);

    logic [DW:0]   trial_hi;
    logic [DW-1:0] diff;

    always_comb begin
        // Upper half after the shift needs one extra bit: the remainder is
        // below the divisor, so doubling it can reach DW+1 bits.
        trial_hi = rem_in[2*DW-1:DW-1];
        q_bit    = (trial_hi >= {1'b0, divisor});
        // When the trial succeeds the true difference is below the divisor,
        // so the truncated DW-bit subtraction is exact.
        diff     = trial_hi[DW-1:0] - divisor;
        if (q_bit) begin
            rem_out = {diff, rem_in[DW-2:0], 1'b0};
        end else begin
            rem_out = {rem_in[2*DW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ysyx_23060077_ex_div.sv
// rtl/ysyx_23060077_ex_div.sv - 32-bit iterative RV32M divider (DIV/DIVU/REM/REMU)
// Purpose: IDLE -> PREP -> CALC (32 restoring steps) -> FIX; result 34 edges
//          after acceptance, flush aborts from any state.
// Ports: clock - rising-edge clock
//        reset - synchronous active-high reset
//        bus   - ysyx_23060077_ex_div_if.slave (operands, flush, handshake, results)
// Macro: YSYX_23060077_DIV_FAST_SPECIAL_EN - finish divide-by-zero and signed
//        overflow in PREP with latency 1.
module ysyx_23060077_ex_div
    import ysyx_23060077_ex_div_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    ysyx_23060077_ex_div_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    state_e          state_q,     state_d;
    logic            div_ready_q, div_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   quotient_q,  quotient_d;
    logic [DW-1:0]   remainder_q, remainder_d;
    logic            sgn_q,       sgn_d;
    logic [DW-1:0]   dividend_q,  dividend_d;
    logic [DW-1:0]   divisor_q,   divisor_d;
    logic [DW-1:0]   dsr_mag_q,   dsr_mag_d;
    logic            q_neg_q,     q_neg_d;
    logic            r_neg_q,     r_neg_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [2*DW-1:0] prem_q,      prem_d;

    logic [2*DW-1:0] step_rem;
    logic            step_qbit;
    logic            div_zero;
    logic            sig_ovf;
    logic [DW-1:0]   q_fix;
    logic [DW-1:0]   r_fix;

    ysyx_23060077_div_step u_step (
        .rem_in  (prem_q),
        .divisor (dsr_mag_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    // Special cases are judged on the raw latched operands.
    assign div_zero = (divisor_q == {DW{1'b0}});
    assign sig_ovf  = sgn_q && (dividend_q == INT_MIN) && (divisor_q == {DW{1'b1}});

    always_comb begin
        q_fix = q_neg_q ? ({DW{1'b0}} - prem_q[DW-1:0]) : prem_q[DW-1:0];
        r_fix = r_neg_q ? ({DW{1'b0}} - prem_q[2*DW-1:DW]) : prem_q[2*DW-1:DW];
        // The plain datapath gets the divide-by-zero quotient sign wrong for a
        // negative dividend, so both special results are forced here.
        if (div_zero) begin
            q_fix = {DW{1'b1}};
            r_fix = dividend_q;
        end else if (sig_ovf) begin
            q_fix = INT_MIN;
            r_fix = {DW{1'b0}};
        end
    end

    always_comb begin
        state_d     = state_q;
        div_ready_d = div_ready_q;
        out_valid_d = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        sgn_d       = sgn_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        dsr_mag_d   = dsr_mag_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;

        unique case (state_q)
            ST_IDLE: begin
                div_ready_d = 1'b1;
                if (bus.div_valid) begin
                    sgn_d       = bus.div_signed;
                    dividend_d  = bus.dividend;
                    divisor_d   = bus.divisor;
                    div_ready_d = 1'b0;
                    state_d     = ST_PREP;
                end
            end
            ST_PREP: begin
                dsr_mag_d = mag(divisor_q, sgn_q);
                prem_d    = {{DW{1'b0}}, mag(dividend_q, sgn_q)};
                q_neg_d   = sgn_q && (dividend_q[DW-1] ^ divisor_q[DW-1]);
                r_neg_d   = sgn_q && dividend_q[DW-1];
                cnt_d     = {CW{1'b0}};
                state_d   = ST_CALC;
`ifdef YSYX_23060077_DIV_FAST_SPECIAL_EN
                if (div_zero || sig_ovf) begin
                    quotient_d  = q_fix;
                    remainder_d = r_fix;
                    out_valid_d = 1'b1;
                    div_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
`endif
            end
            ST_CALC: begin
                prem_d = step_rem | {{(2*DW-1){1'b0}}, step_qbit};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                quotient_d  = q_fix;
                remainder_d = r_fix;
                out_valid_d = 1'b1;
                div_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush wins over everything, including a result being written.
        if (bus.flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            div_ready_d = 1'b1;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= {DW{1'b0}};
            remainder_q <= {DW{1'b0}};
            sgn_q       <= 1'b0;
            dividend_q  <= {DW{1'b0}};
            divisor_q   <= {DW{1'b0}};
            dsr_mag_q   <= {DW{1'b0}};
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            prem_q      <= {(2*DW){1'b0}};
        end else begin
            state_q     <= state_d;
            div_ready_q <= div_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            sgn_q       <= sgn_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            dsr_mag_q   <= dsr_mag_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
        end
    end

    assign bus.div_ready = div_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_23060077_ex_div.sv
// tb/tb_ysyx_23060077_ex_div.sv - directed self-checking bench for ysyx_23060077_ex_div
module tb_ysyx_23060077_ex_div;

`ifdef YSYX_23060077_DIV_FAST_SPECIAL_EN
    localparam int LAT_SP = 1;
`else
    localparam int LAT_SP = 34;
`endif
    localparam int LAT = 34;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;
    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    ysyx_23060077_ex_div_if bus();

    ysyx_23060077_ex_div dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.div_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check({tag, " ready"}, {31'd0, bus.div_ready}, 32'd1);
    endtask

    // Counts out_valid pulses over a window where none are allowed.
    task automatic expect_quiet(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.out_valid === 1'b1) pulses++;
        end
        check({tag, " no pulse"}, pulses, 32'd0);
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input int elat);
        int  lat  = 0;
        bit  seen = 0;
        wait_ready(tag);
        bus.div_signed = sgn;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_valid  = 1'b1;
        tick();
        bus.div_valid  = 1'b0;
        check({tag, " busy"}, {31'd0, bus.div_ready}, 32'd0);
        while (!seen && lat < 100) begin
            tick();
            lat++;
            if (bus.out_valid === 1'b1) seen = 1;
        end
        check({tag, " lat"}, lat, elat);
        check({tag, " q"}, bus.quotient, eq);
        check({tag, " r"}, bus.remainder, er);
        tick();
        check({tag, " pulse"}, {31'd0, bus.out_valid}, 32'd0);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd0;
        bus.divisor    = 32'd0;
        bus.flush      = 1'b0;
        bus.div_valid  = 1'b0;

        repeat (3) tick();
        check("rst ready", {31'd0, bus.div_ready}, 32'd0);
        check("rst valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst q", bus.quotient, 32'd0);
        check("rst r", bus.remainder, 32'd0);
        reset = 1'b0;
        tick();
        check("rst ready rise", {31'd0, bus.div_ready}, 32'd1);

        // Directed vectors; consecutive calls also exercise back-to-back issue.
        run_div("u100/7",   1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        LAT);
        run_div("s-7/2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, LAT);
        run_div("uFFF9/2",  1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        LAT);
        run_div("s7/-2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        LAT);
        run_div("s-7/-2",   1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, LAT);
        run_div("s/0",      1'b1, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, LAT_SP);
        run_div("u/0",      1'b0, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, LAT_SP);
        run_div("sneg/0",   1'b1, 32'h80000001, 32'd0,        32'hFFFFFFFF, 32'h80000001, LAT_SP);
        run_div("s ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        LAT_SP);
        run_div("u ovfops", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, LAT);
        run_div("uMax/1",   1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        LAT);
        run_div("u0/5",     1'b0, 32'd0,        32'd5,        32'd0,        32'd0,        LAT);
        run_div("sMin/1",   1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'd0,        LAT);
        run_div("uMax/msb", 1'b0, 32'hFFFFFFFF, 32'h80000000, 32'd1,        32'h7FFFFFFF, LAT);

        // Flush ten edges after acceptance.
        wait_ready("flush10");
        bus.div_signed = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'd7; bus.div_valid = 1'b1;
        tick();
        bus.div_valid = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush10 ready", {31'd0, bus.div_ready}, 32'd1);
        check("flush10 valid", {31'd0, bus.out_valid}, 32'd0);
        expect_quiet("flush10", 40);
        check("flush10 q", bus.quotient, last_q);
        check("flush10 r", bus.remainder, last_r);
        run_div("u1000/10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, LAT);

        // Flush coincident with FIX.
        wait_ready("flushfix");
        bus.div_signed = 1'b0; bus.dividend = 32'd91; bus.divisor = 32'd7; bus.div_valid = 1'b1;
        tick();
        bus.div_valid = 1'b0;
        repeat (33) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flushfix valid", {31'd0, bus.out_valid}, 32'd0);
        check("flushfix q", bus.quotient, last_q);
        check("flushfix r", bus.remainder, last_r);
        check("flushfix ready", {31'd0, bus.div_ready}, 32'd1);
        expect_quiet("flushfix", 5);

        // Request coincident with flush in IDLE is dropped.
        wait_ready("flushreq");
        bus.div_signed = 1'b0; bus.dividend = 32'd5; bus.divisor = 32'd1; bus.div_valid = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.div_valid = 1'b0;
        check("flushreq ready", {31'd0, bus.div_ready}, 32'd1);
        expect_quiet("flushreq", 40);
        check("flushreq q", bus.quotient, last_q);

        // div_valid held while busy with changing operands is ignored.
        wait_ready("busyhold");
        bus.div_signed = 1'b0; bus.dividend = 32'd200; bus.divisor = 32'd3; bus.div_valid = 1'b1;
        tick();
        bus.dividend = 32'd9; bus.divisor = 32'd1;
        lat = 0;
        repeat (20) begin tick(); lat++; end
        bus.div_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
        check("busyhold lat", lat, LAT);
        check("busyhold q", bus.quotient, 32'd66);
        check("busyhold r", bus.remainder, 32'd2);
        tick();
        last_q = 32'd66; last_r = 32'd2;

        // Reset twenty edges after acceptance.
        wait_ready("rstmid");
        bus.div_signed = 1'b0; bus.dividend = 32'd123; bus.divisor = 32'd4; bus.div_valid = 1'b1;
        tick();
        bus.div_valid = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid ready", {31'd0, bus.div_ready}, 32'd0);
        check("rstmid valid", {31'd0, bus.out_valid}, 32'd0);
        check("rstmid q", bus.quotient, 32'd0);
        check("rstmid r", bus.remainder, 32'd0);
        tick();
        check("rstmid ready rise", {31'd0, bus.div_ready}, 32'd1);
        expect_quiet("rstmid", 40);
        run_div("u50/5",  1'b0, 32'd50, 32'd5, 32'd10, 32'd0, LAT);
        run_div("b2b s",  1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, LAT);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_ex_div.md
YSYX_23060077_EX_DIV -- requirements
Module: ysyx_23060077_ex_div

Interface
REQ-001 SHALL have no module parameters; operand width is YSYX_23060077_DATA_WIDTH (32) from the shared define file.
REQ-002 clock  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-005 dividend  input  32  numerator.
REQ-006 divisor  input  32  denominator.
REQ-007 flush  input  1  abort any operation in progress.
REQ-008 div_valid  input  1  request; operands are sampled when div_valid=1 and the state is IDLE.
REQ-009 div_ready  output  1  registered; high while idle and able to accept.
REQ-010 out_valid  output  1  registered, one-cycle pulse marking a valid result.
REQ-011 quotient  output  32  registered quotient, held until the next result.
REQ-012 remainder  output  32  registered remainder, held until the next result.

Function
REQ-013 SHALL implement states IDLE, PREP, CALC and FIX.
REQ-014 IDLE: div_ready<=1, out_valid<=0; on div_valid (and no flush), latch div_signed/dividend/divisor, div_ready<=0, go to PREP (acceptance edge T).
REQ-015 PREP: compute operand magnitudes (two's-complement abs when signed and the MSB is set), record quotient sign (signs differ) and remainder sign (dividend sign), clear the 5-bit iteration counter, go to CALC at edge T+1.
REQ-016 CALC: one radix-2 restoring step per cycle (shift the 64-bit partial remainder left, trial-subtract divisor, set the quotient bit when non-negative); after 32 steps (edges T+2..T+33) go to FIX.
REQ-017 FIX: apply sign correction, register quotient/remainder, pulse out_valid, go to IDLE at edge T+34; normal latency is 34 edges from acceptance.
REQ-018 Divide by zero SHALL give quotient=0xFFFFFFFF and remainder=dividend, signed or unsigned.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient=0x80000000 and remainder=0.
REQ-020 Remainder sign SHALL follow the dividend and quotient SHALL truncate toward zero (RV32M semantics).
REQ-021 div_ready SHALL be 0 in PREP, CALC and FIX; div_valid there is ignored and operands are not re-latched.
REQ-022 flush SHALL have priority in every state: next state IDLE, out_valid<=0, div_ready<=1, no result update; div_valid coincident with flush is not accepted.
REQ-023 flush in the same cycle as FIX SHALL suppress out_valid and leave quotient/remainder unchanged.
REQ-024 Back-to-back: a request presented in the cycle after out_valid (IDLE, div_ready=1) SHALL be accepted.

Reset
REQ-025 reset SHALL force: IDLE, div_ready=0, out_valid=0, quotient=0, remainder=0, latched operands, counter and partial remainder=0.
REQ-026 div_ready SHALL rise at the first edge after reset deasserts.
REQ-027 reset mid-operation SHALL discard the operation with no out_valid.

Configuration
REQ-028 Macro YSYX_23060077_DIV_FAST_SPECIAL_EN defined: PREP detects divide-by-zero and signed overflow, writes the REQ-018/019 results, pulses out_valid and returns to IDLE at edge T+1 (latency 1).
REQ-029 Macro undefined: special cases traverse CALC/FIX with latency 34; results are identical (FIX applies the REQ-018/019 override).

Structure
REQ-030 YSYX_23060077_DATA_WIDTH SHALL come from the shared ysyx_23060077_define.v; the macro is tested there; the state encoding is local.
REQ-031 One combinational sub-module, ysyx_23060077_div_step: 64-bit partial remainder and 32-bit divisor in, next partial remainder and quotient bit out.

Verification
REQ-032 Unsigned 100/7 -> quotient=14, remainder=2, out_valid exactly 34 edges after acceptance, single-cycle pulse.
REQ-033 Signed 0xFFFFFFF9/2 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned same operands -> 0x7FFFFFFC, 1.
REQ-034 0x12345678/0 (signed and unsigned) -> quotient=0xFFFFFFFF, remainder=0x12345678; latency 1 with the macro, 34 without.
REQ-035 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned -> quotient=0, remainder=0x80000000.
REQ-036 flush at T+10 -> no out_valid, outputs unchanged, div_ready=1 next cycle; next request 1000/10 -> quotient=100, remainder=0.
REQ-037 reset at T+20 then 50/5 -> no stale pulse; quotient=10, remainder=0; back-to-back requests each produce one out_valid.
